pipeline_control: RTL and testbench

Hazard and sequencing controller for the five-stage Y86-64 pipeline. It reads the icode, register-ID and status fields that the F/D/E/M/W pipeline registers and stage logic already expose, and generates the per-register stall/bubble controls. It also owns the pipeline run state: a post-reset flush, normal running, exception drain, and halted. It sits beside the pipeline registers in the top level and is the only source of their stall/bubble inputs.

---
 rtl/pipeline_control.sv | 148 ++++++++++++++
 tb/tb_pipeline_control.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// pipeline_control: Y86-64 hazard stall/bubble generator and INIT/RUN/DRAIN/HALTED sequencer.
// Controls are combinational from inputs and state; PIPE_CTRL_PERF_EN builds the perf counters.
module pipeline_control #(
   parameter int INIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_destM,
   input  logic        e_Cnd,
   input  logic [3:0]  M_icode,
   input  logic [2:0]  m_stat,
   input  logic [2:0]  W_stat,
   output logic        F_stall,
   output logic        D_stall,
   output logic        W_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        M_bubble,
   output logic        halted,
   output logic [1:0]  run_state,
   output logic [31:0] perf_cycles,
   output logic [31:0] perf_stalls,
   output logic [31:0] perf_mispred,
   output logic [31:0] perf_rets
);
   localparam logic [3:0] IRET      = 4'h9;
   localparam logic [3:0] IJXX      = 4'h7;
   localparam logic [3:0] IMRMOVQ   = 4'h5;
   localparam logic [3:0] IPOPQ     = 4'hB;
   localparam logic [3:0] RNONE     = 4'hF;
   localparam logic [2:0] SAOK      = 3'd1;
   localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   state_e     state_q;
   logic [3:0] init_cnt_q;

   logic load_use, mispred, ret_any, m_exc, w_exc;

   assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_destM != RNONE) &&
                     ((E_destM == d_srcA) || (E_destM == d_srcB));
   assign mispred  = (E_icode == IJXX) && !e_Cnd;
   assign ret_any  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
   assign m_exc    = (m_stat != SAOK);
   assign w_exc    = (W_stat != SAOK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= 4'd0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (init_cnt_q == INIT_LAST) state_q <= ST_RUN;
               else                         init_cnt_q <= init_cnt_q + 4'd1;
            end
            // A write-back exception outranks a newer memory-stage one.
            ST_RUN: begin
               if (w_exc)      state_q <= ST_HALTED;
               else if (m_exc) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_exc) state_q <= ST_HALTED;
            end
            ST_HALTED: state_q <= ST_HALTED;
            default:   state_q <= ST_INIT;
         endcase
      end
   end

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
         ST_RUN, ST_DRAIN: begin
            F_stall  = load_use || ret_any;
            D_stall  = load_use;
            D_bubble = (mispred || (ret_any && !load_use)) && !load_use;
            E_bubble = mispred || load_use;
            M_bubble = m_exc || w_exc;
            W_stall  = w_exc;
         end
         ST_HALTED: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted    = (state_q == ST_HALTED);
   assign run_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_stalls_q, perf_mispred_q, perf_rets_q;
   logic        active;

   assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q  <= 32'd0;
         perf_stalls_q  <= 32'd0;
         perf_mispred_q <= 32'd0;
         perf_rets_q    <= 32'd0;
      end else if (active) begin
         perf_cycles_q <= perf_cycles_q + 32'd1;
         if (F_stall)           perf_stalls_q  <= perf_stalls_q + 32'd1;
         if (mispred)           perf_mispred_q <= perf_mispred_q + 32'd1;
         if (D_icode == IRET)   perf_rets_q    <= perf_rets_q + 32'd1;
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_stalls  = perf_stalls_q;
   assign perf_mispred = perf_mispred_q;
   assign perf_rets    = perf_rets_q;
`else
   assign perf_cycles  = 32'd0;
   assign perf_stalls  = 32'd0;
   assign perf_mispred = 32'd0;
   assign perf_rets    = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: stimulus pushes expected controls, a negedge monitor pops and compares.
module tb_pipeline_control;
   localparam int INIT_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode;
   logic        e_Cnd;
   logic [2:0]  m_stat, W_stat;
   logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted;
   logic [1:0]  run_state;
   logic [31:0] perf_cycles, perf_stalls, perf_mispred, perf_rets;

   pipeline_control #(.INIT_CYCLES(INIT_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_destM(E_destM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
      .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
      .halted(halted), .run_state(run_state),
      .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
      .perf_mispred(perf_mispred), .perf_rets(perf_rets)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fs, ds, ws, db, eb, mb, hl;
      logic [1:0]  rs;
      logic [31:0] pc, ps, pm, pr;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: run state as a plain integer, INIT tracked as edges seen since release.
   int          m_state;
   int          m_edges;
   logic [31:0] m_pc, m_ps, m_pm, m_pr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic hz_lu();
      return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_destM != 4'hF) &&
             ((E_destM == d_srcA) || (E_destM == d_srcB));
   endfunction
   function automatic logic hz_mp();
      return (E_icode == 4'h7) && !e_Cnd;
   endfunction
   function automatic logic hz_ret();
      return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      logic lu, mp, ra;
      lu = hz_lu(); mp = hz_mp(); ra = hz_ret();
      e.rs = 2'(m_state);
      e.hl = (m_state == 3);
      e.pc = m_pc; e.ps = m_ps; e.pm = m_pm; e.pr = m_pr;
      if (m_state == 0) begin
         e.fs = 1; e.ds = 0; e.ws = 0; e.db = 1; e.eb = 1; e.mb = 1;
      end else if (m_state == 3) begin
         e.fs = 1; e.ds = 1; e.ws = 1; e.db = 0; e.eb = 1; e.mb = 1;
      end else begin
         e.fs = lu || ra;
         e.ds = lu;
         e.db = lu ? 1'b0 : (mp || ra);
         e.eb = mp || lu;
         e.mb = (m_stat != 3'd1) || (W_stat != 3'd1);
         e.ws = (W_stat != 3'd1);
      end
      return e;
   endfunction

   task automatic model_reset();
      m_state = 0; m_edges = 0;
      m_pc = 0; m_ps = 0; m_pm = 0; m_pr = 0;
   endtask

   // Advance the model across one rising edge using the inputs held during the cycle before it.
   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
`ifdef PIPE_CTRL_PERF_EN
         if (m_state == 1 || m_state == 2) begin
            m_pc++;
            if (hz_lu() || hz_ret()) m_ps++;
            if (hz_mp())             m_pm++;
            if (D_icode == 4'h9)     m_pr++;
         end
`endif
         case (m_state)
            0: begin
               m_edges++;
               if (m_edges == INIT_CYCLES) m_state = 1;
            end
            1: m_state = (W_stat != 3'd1) ? 3 : (m_stat != 3'd1) ? 2 : 1;
            2: m_state = (W_stat != 3'd1) ? 3 : 2;
            default: m_state = 3;
         endcase
      end
   endtask

   task automatic apply(input logic rv, input logic [3:0] di, input logic [3:0] ei,
                        input logic [3:0] edm, input logic [3:0] sa, input logic [3:0] sb,
                        input logic ec, input logic [3:0] mi, input logic [2:0] ms,
                        input logic [2:0] ws);
      @(posedge clk);
      model_edge();
      #1;
      rst_n = rv;
      if (!rv) model_reset();
      D_icode = di; E_icode = ei; E_destM = edm; d_srcA = sa; d_srcB = sb;
      e_Cnd = ec; M_icode = mi; m_stat = ms; W_stat = ws;
      q.push_back(expect_now());
   endtask

   function automatic logic [3:0] r_icode();
      case ($urandom_range(0, 6))
         0: return 4'h5;
         1: return 4'hB;
         2: return 4'h7;
         3: return 4'h9;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction
   function automatic logic [3:0] r_reg();
      case ($urandom_range(0, 3))
         0: return 4'h3;
         1: return 4'h4;
         2: return 4'hF;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction
   function automatic logic [2:0] r_stat(input int exc_1_in);
      if (exc_1_in == 0) return 3'd1;
      if ($urandom_range(1, exc_1_in) == 1) return 3'($urandom_range(0, 7));
      return 3'd1;
   endfunction

   task automatic rnd(input logic rv, input int exc_1_in);
      apply(rv, r_icode(), r_icode(), r_reg(), r_reg(), r_reg(), 1'($urandom_range(0, 1)),
            r_icode(), r_stat(exc_1_in), r_stat(exc_1_in));
   endtask

   task automatic async_reset();
      @(posedge clk);
      model_edge();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_halted", 32'(halted), 32'd0);
      chk("async_state", 32'(run_state), 32'd0);
      chk("async_perf_cycles", perf_cycles, 32'd0);
      chk("async_perf_stalls", perf_stalls, 32'd0);
      q.push_back(expect_now());
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("F_stall", 32'(F_stall), 32'(e.fs));
         chk("D_stall", 32'(D_stall), 32'(e.ds));
         chk("W_stall", 32'(W_stall), 32'(e.ws));
         chk("D_bubble", 32'(D_bubble), 32'(e.db));
         chk("E_bubble", 32'(E_bubble), 32'(e.eb));
         chk("M_bubble", 32'(M_bubble), 32'(e.mb));
         chk("halted", 32'(halted), 32'(e.hl));
         chk("run_state", 32'(run_state), 32'(e.rs));
         chk("perf_cycles", perf_cycles, e.pc);
         chk("perf_stalls", perf_stalls, e.ps);
         chk("perf_mispred", perf_mispred, e.pm);
         chk("perf_rets", perf_rets, e.pr);
      end
   end

   initial begin
      rst_n = 1'b0;
      D_icode = 0; E_icode = 0; E_destM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
      e_Cnd = 1'b1; M_icode = 0; m_stat = 3'd1; W_stat = 3'd1;
      model_reset();
      #1;
      chk("reset_state", 32'(run_state), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);

      repeat (3) rnd(1'b0, 2);
      repeat (INIT_CYCLES + 2) rnd(1'b1, 0);

      // Directed: load-use, no hazard, ret walking D->E->M, release, mispredict.
      apply(1, 4'h0, 4'h5, 4'h3, 4'h3, 4'hF, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h5, 4'h3, 4'h4, 4'h4, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h9, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h9, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h9, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h7, 4'h3, 4'h3, 4'h3, 0, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd1);

      repeat (300) rnd(1'b1, 0);

      // Exception: DRAIN on m_stat, then HALTED on W_stat, then frozen.
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd3, 3'd1);
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd1);
      apply(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'h0, 3'd1, 3'd3);
      repeat (100) rnd(1'b1, 1);

      async_reset();
      repeat (2) rnd(1'b0, 1);
      repeat (400) rnd(1'b1, 40);
      async_reset();
      rnd(1'b0, 0);
      repeat (200) rnd(1'b1, 25);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
